// File: rtl/trap_sequencer.sv
// Interrupt entry / MRET exit sequencer: drains the pipe, writes mepc/mcause, redirects fetch.
// Optional macro TRAP_VECTORED_EN enables mtvec vectored mode (mtvec[1:0]==2'b01).
module trap_sequencer (
  input  logic        clk,
  input  logic        rst,
  input  logic        interrupt_pending,
  input  logic [31:0] interrupt_cause,
  input  logic        mret_req,
  input  logic        pipe_idle,
  input  logic [31:0] current_pc,
  input  logic [31:0] mtvec,
  input  logic [31:0] mepc,
  output logic        stall,
  output logic        flush,
  output logic        pc_redirect,
  output logic [31:0] redirect_pc,
  output logic        csr_we,
  output logic [31:0] mepc_wdata,
  output logic [31:0] mcause_wdata,
  output logic        trap_enter,
  output logic        trap_exit,
  output logic        interrupt_taken,
  output logic        busy
);

  localparam int unsigned XLEN = 32;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DRAIN  = 3'd1,
    SAVE   = 3'd2,
    VECTOR = 3'd3,
    RETURN = 3'd4
  } state_t;

  state_t state;
  state_t state_next;

  logic [XLEN-1:0] vector_base;
  logic [XLEN-1:0] vector_pc;
  logic [XLEN-1:0] return_pc;
  logic [XLEN-1:0] capture_pc;
  logic            unused_low_bits;

  assign vector_base     = {mtvec[31:2], 2'b00};
  assign return_pc       = {mepc[31:2], 2'b00};
  assign capture_pc      = {current_pc[31:2], 2'b00};
  assign unused_low_bits = ^{mtvec[1:0], mepc[1:0], current_pc[1:0]};

  // mcause_wdata holds the latched cause during SAVE, which is when VECTOR's target is computed.
`ifdef TRAP_VECTORED_EN
  always_comb begin
    vector_pc = vector_base;
    if (mtvec[1:0] == 2'b01) begin
      vector_pc = vector_base + XLEN'({mcause_wdata[4:0], 2'b00});
    end
  end
`else
  assign vector_pc = vector_base;
`endif

  // MRET outranks a simultaneous interrupt; a withdrawn request abandons the drain.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (mret_req) begin
          state_next = RETURN;
        end else if (interrupt_pending) begin
          state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (!interrupt_pending) begin
          state_next = IDLE;
        end else if (pipe_idle) begin
          state_next = SAVE;
        end
      end
      SAVE:    state_next = VECTOR;
      VECTOR:  state_next = IDLE;
      RETURN:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from the next state so each one is a clean Moore decode.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      stall           <= 1'b0;
      flush           <= 1'b0;
      pc_redirect     <= 1'b0;
      redirect_pc     <= '0;
      csr_we          <= 1'b0;
      mepc_wdata      <= '0;
      mcause_wdata    <= '0;
      trap_enter      <= 1'b0;
      trap_exit       <= 1'b0;
      interrupt_taken <= 1'b0;
      busy            <= 1'b0;
    end else begin
      state           <= state_next;
      stall           <= (state_next == DRAIN) || (state_next == SAVE) || (state_next == VECTOR);
      flush           <= (state_next == VECTOR) || (state_next == RETURN);
      pc_redirect     <= (state_next == VECTOR) || (state_next == RETURN);
      csr_we          <= (state_next == SAVE);
      trap_enter      <= (state_next == SAVE);
      interrupt_taken <= (state_next == SAVE);
      trap_exit       <= (state_next == RETURN);
      busy            <= (state_next != IDLE);

      if (state_next == SAVE) begin
        mepc_wdata   <= capture_pc;
        mcause_wdata <= interrupt_cause;
      end else begin
        mepc_wdata   <= '0;
        mcause_wdata <= '0;
      end

      case (state_next)
        VECTOR:  redirect_pc <= vector_pc;
        RETURN:  redirect_pc <= return_pc;
        default: redirect_pc <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// Directed bench for trap_sequencer: entry latency, drain wait, withdrawal, MRET priority, reset, vectoring.
module tb_trap_sequencer;

  logic        clk;
  logic        rst;
  logic        interrupt_pending;
  logic [31:0] interrupt_cause;
  logic        mret_req;
  logic        pipe_idle;
  logic [31:0] current_pc;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic        stall;
  logic        flush;
  logic        pc_redirect;
  logic [31:0] redirect_pc;
  logic        csr_we;
  logic [31:0] mepc_wdata;
  logic [31:0] mcause_wdata;
  logic        trap_enter;
  logic        trap_exit;
  logic        interrupt_taken;
  logic        busy;

  int tests_run = 0;
  int tests_failed = 0;

  trap_sequencer dut (
    .clk(clk), .rst(rst),
    .interrupt_pending(interrupt_pending), .interrupt_cause(interrupt_cause),
    .mret_req(mret_req), .pipe_idle(pipe_idle), .current_pc(current_pc),
    .mtvec(mtvec), .mepc(mepc),
    .stall(stall), .flush(flush), .pc_redirect(pc_redirect), .redirect_pc(redirect_pc),
    .csr_we(csr_we), .mepc_wdata(mepc_wdata), .mcause_wdata(mcause_wdata),
    .trap_enter(trap_enter), .trap_exit(trap_exit),
    .interrupt_taken(interrupt_taken), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one cycle; inputs change and outputs are sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, ".busy"}, 32'(busy), 32'd0);
    chk({tag, ".stall"}, 32'(stall), 32'd0);
    chk({tag, ".flush"}, 32'(flush), 32'd0);
    chk({tag, ".pc_redirect"}, 32'(pc_redirect), 32'd0);
    chk({tag, ".redirect_pc"}, redirect_pc, 32'h0);
    chk({tag, ".csr_we"}, 32'(csr_we), 32'd0);
    chk({tag, ".trap_enter"}, 32'(trap_enter), 32'd0);
    chk({tag, ".trap_exit"}, 32'(trap_exit), 32'd0);
  endtask

  logic [31:0] exp_vec;

  initial begin
    rst = 1'b1;
    interrupt_pending = 1'b0;
    interrupt_cause = 32'h0;
    mret_req = 1'b0;
    pipe_idle = 1'b0;
    current_pc = 32'h0;
    mtvec = 32'h0;
    mepc = 32'h0;
    #12;
    chk_quiet("reset");
    chk("reset.mepc_wdata", mepc_wdata, 32'h0);
    chk("reset.mcause_wdata", mcause_wdata, 32'h0);
    step();
    rst = 1'b0;
    step();
    chk_quiet("post_reset");

    // Timer interrupt with idle pipe: DRAIN, SAVE, VECTOR, IDLE.
    pipe_idle = 1'b1;
    interrupt_cause = 32'h8000_0007;
    current_pc = 32'h0000_0100;
    mtvec = 32'h0000_0200;
    interrupt_pending = 1'b1;
    step();
    chk("timer.drain.stall", 32'(stall), 32'd1);
    chk("timer.drain.busy", 32'(busy), 32'd1);
    chk("timer.drain.csr_we", 32'(csr_we), 32'd0);
    step();
    chk("timer.save.csr_we", 32'(csr_we), 32'd1);
    chk("timer.save.trap_enter", 32'(trap_enter), 32'd1);
    chk("timer.save.taken", 32'(interrupt_taken), 32'd1);
    chk("timer.save.mepc", mepc_wdata, 32'h0000_0100);
    chk("timer.save.mcause", mcause_wdata, 32'h8000_0007);
    chk("timer.save.pc_redirect", 32'(pc_redirect), 32'd0);
    interrupt_pending = 1'b0;
    step();
    chk("timer.vector.redirect_pc", redirect_pc, 32'h0000_0200);
    chk("timer.vector.flush", 32'(flush), 32'd1);
    chk("timer.vector.pc_redirect", 32'(pc_redirect), 32'd1);
    chk("timer.vector.stall", 32'(stall), 32'd1);
    chk("timer.vector.csr_we", 32'(csr_we), 32'd0);
    chk("timer.vector.mepc", mepc_wdata, 32'h0);
    step();
    chk_quiet("timer.idle");

    // Drain wait: pipe busy 5 cycles, higher-priority cause appears mid-drain; MRET ignored there.
    pipe_idle = 1'b0;
    current_pc = 32'h0000_0203;
    interrupt_cause = 32'h8000_0007;
    interrupt_pending = 1'b1;
    step();
    for (int k = 1; k <= 5; k++) begin
      chk($sformatf("drain.c%0d.stall", k), 32'(stall), 32'd1);
      chk($sformatf("drain.c%0d.csr_we", k), 32'(csr_we), 32'd0);
      chk($sformatf("drain.c%0d.flush", k), 32'(flush), 32'd0);
      chk($sformatf("drain.c%0d.trap_exit", k), 32'(trap_exit), 32'd0);
      if (k == 2) mret_req = 1'b1;
      if (k == 3) interrupt_cause = 32'h8000_000B;
      if (k == 4) mret_req = 1'b0;
      step();
    end
    pipe_idle = 1'b1;
    chk("drain.c6.stall", 32'(stall), 32'd1);
    chk("drain.c6.csr_we", 32'(csr_we), 32'd0);
    step();
    chk("drain.save.csr_we", 32'(csr_we), 32'd1);
    chk("drain.save.mcause", mcause_wdata, 32'h8000_000B);
    chk("drain.save.mepc", mepc_wdata, 32'h0000_0200);
    interrupt_pending = 1'b0;
    step();
    chk("drain.vector.redirect_pc", redirect_pc, 32'h0000_0200);
    step();
    chk_quiet("drain.idle");

    // Withdrawn request: DRAIN then straight back to IDLE.
    pipe_idle = 1'b0;
    interrupt_pending = 1'b1;
    step();
    chk("withdraw.drain.busy", 32'(busy), 32'd1);
    interrupt_pending = 1'b0;
    step();
    chk_quiet("withdraw.idle");
    step();
    chk_quiet("withdraw.idle2");

    // MRET and interrupt together: MRET first, interrupt taken from the following IDLE.
    pipe_idle = 1'b1;
    mepc = 32'h0000_0104;
    current_pc = 32'h0000_0300;
    interrupt_cause = 32'h8000_0003;
    mret_req = 1'b1;
    interrupt_pending = 1'b1;
    step();
    chk("mret.return.trap_exit", 32'(trap_exit), 32'd1);
    chk("mret.return.redirect_pc", redirect_pc, 32'h0000_0104);
    chk("mret.return.flush", 32'(flush), 32'd1);
    chk("mret.return.pc_redirect", 32'(pc_redirect), 32'd1);
    chk("mret.return.stall", 32'(stall), 32'd0);
    chk("mret.return.csr_we", 32'(csr_we), 32'd0);
    chk("mret.return.busy", 32'(busy), 32'd1);
    mret_req = 1'b0;
    step();
    chk_quiet("mret.idle");
    step();
    chk("mret.drain.stall", 32'(stall), 32'd1);
    chk("mret.drain.csr_we", 32'(csr_we), 32'd0);
    step();
    chk("mret.save.csr_we", 32'(csr_we), 32'd1);
    chk("mret.save.mepc", mepc_wdata, 32'h0000_0300);
    chk("mret.save.mcause", mcause_wdata, 32'h8000_0003);
    interrupt_pending = 1'b0;
    step();
    step();
    chk_quiet("mret.idle2");

    // Asynchronous reset in the middle of SAVE.
    interrupt_cause = 32'h8000_0007;
    current_pc = 32'h0000_0100;
    interrupt_pending = 1'b1;
    step();
    step();
    chk("rst_save.pre.csr_we", 32'(csr_we), 32'd1);
    #2;
    rst = 1'b1;
    #1;
    chk_quiet("rst_save");
    chk("rst_save.mepc", mepc_wdata, 32'h0);
    chk("rst_save.mcause", mcause_wdata, 32'h0);
    chk("rst_save.taken", 32'(interrupt_taken), 32'd0);
    interrupt_pending = 1'b0;
    step();
    rst = 1'b0;
    step();
    chk_quiet("rst_save.after");

    // Vectored-mode mtvec.
`ifdef TRAP_VECTORED_EN
    exp_vec = 32'h0000_021C;
`else
    exp_vec = 32'h0000_0200;
`endif
    mtvec = 32'h0000_0201;
    interrupt_cause = 32'h8000_0007;
    interrupt_pending = 1'b1;
    step();
    step();
    interrupt_pending = 1'b0;
    step();
    chk("vectored.redirect_pc", redirect_pc, exp_vec);
    chk("vectored.pc_redirect", 32'(pc_redirect), 32'd1);
    step();
    chk_quiet("vectored.idle");

    // Reserved mtvec mode behaves as direct in every build.
    mtvec = 32'h0000_0202;
    interrupt_pending = 1'b1;
    step();
    step();
    interrupt_pending = 1'b0;
    step();
    chk("mode2.redirect_pc", redirect_pc, 32'h0000_0200);
    step();
    chk_quiet("mode2.idle");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
